// File: rtl/draw_arbiter.sv
// Framebuffer write-port owner: full-frame raster clear, then round-robin packet arbitration of N pixel sources.
// Optional statistics (drop_count, pkt_count) are built when DRAW_ARB_STATS_EN is defined.
module draw_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 9,
  parameter int unsigned CW      = 1,
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic [CW-1:0]         clear_color,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC-1:0]    src_last,
  input  logic [NUM_SRC*XW-1:0] src_x,
  input  logic [NUM_SRC*YW-1:0] src_y,
  input  logic [NUM_SRC*CW-1:0] src_color,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic [CW-1:0]         pixel_color,
  output logic                  pixel_we,
  output logic                  clearing,
  output logic                  cleared
`ifdef DRAW_ARB_STATS_EN
  ,
  output logic [15:0]           drop_count,
  output logic [NUM_SRC*16-1:0] pkt_count
`endif
);

  localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, SERVE = 2'd2} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   grant, grant_d, ptr, ptr_d, pick;
  logic            pend, pend_d, found;
  logic [CW-1:0]   clr_col, clr_col_d, col_d;
  logic [XW-1:0]   cx, cx_d, x_d, gx;
  logic [YW-1:0]   cy, cy_d, y_d, gy;
  logic [CW-1:0]   gc;
  logic            gl, xfer, clip;
  logic            we_d, clearing_d, cleared_d;
  logic [NUM_SRC-1:0] ready_d;

  // Mux the granted source's payload
  always_comb begin
    gx = '0;
    gy = '0;
    gc = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (PW'(s) == grant) begin
        gx = src_x[s*XW +: XW];
        gy = src_y[s*YW +: YW];
        gc = src_color[s*CW +: CW];
      end
    end
  end

  assign gl   = src_last[grant];
  assign xfer = (state == SERVE) && src_valid[grant] && src_ready[grant];
  assign clip = (32'(gx) >= H_RES) || (32'(gy) >= V_RES);

  // First valid source at or above the pointer, wrapping
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_pw;
    pick   = '0;
    found  = 1'b0;
    idx    = 0;
    idx_pw = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_pw = PW'(idx);
      if (!found && src_valid[idx_pw]) begin
        found = 1'b1;
        pick  = idx_pw;
      end
    end
  end

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    ptr_d      = ptr;
    pend_d     = pend;
    clr_col_d  = clr_col;
    cx_d       = '0;
    cy_d       = '0;
    x_d        = x;
    y_d        = y;
    col_d      = pixel_color;
    we_d       = 1'b0;
    clearing_d = 1'b0;
    cleared_d  = 1'b0;
    ready_d    = '0;
    case (state)
      CLEAR: begin
        x_d        = cx;
        y_d        = cy;
        col_d      = clr_col;
        we_d       = 1'b1;
        clearing_d = 1'b1;
        pend_d     = 1'b0;
        if (32'(cx) == H_RES - 1) begin
          if (32'(cy) == V_RES - 1) begin
            cleared_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cy_d = cy + YW'(1);
          end
        end else begin
          cx_d = cx + XW'(1);
          cy_d = cy;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_col_d = clear_color;
        end else if (found) begin
          state_d = SERVE;
          grant_d = pick;
          ready_d = NUM_SRC'(1) << pick;
        end
      end
      SERVE: begin
        ready_d = NUM_SRC'(1) << grant;
        pend_d  = pend | clear_req;
        if (xfer) begin
          // Clipped beats are consumed but leave the write outputs untouched
          if (!clip) begin
            x_d   = gx;
            y_d   = gy;
            col_d = gc;
            we_d  = 1'b1;
          end
          if (gl) begin
            ready_d = '0;
            ptr_d   = (32'(grant) == NUM_SRC - 1) ? '0 : grant + PW'(1);
            if (pend | clear_req) begin
              state_d   = CLEAR;
              clr_col_d = clear_color;
              pend_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      grant       <= '0;
      ptr         <= '0;
      pend        <= 1'b0;
      clr_col     <= '0;
      cx          <= '0;
      cy          <= '0;
      x           <= '0;
      y           <= '0;
      pixel_color <= '0;
      pixel_we    <= 1'b0;
      src_ready   <= '0;
      clearing    <= 1'b0;
      cleared     <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      ptr         <= ptr_d;
      pend        <= pend_d;
      clr_col     <= clr_col_d;
      cx          <= cx_d;
      cy          <= cy_d;
      x           <= x_d;
      y           <= y_d;
      pixel_color <= col_d;
      pixel_we    <= we_d;
      src_ready   <= ready_d;
      clearing    <= clearing_d;
      cleared     <= cleared_d;
    end
  end

`ifdef DRAW_ARB_STATS_EN
  logic [15:0]           drop_d;
  logic [NUM_SRC*16-1:0] pkt_d;

  // Saturating counters, wiped whenever a new clear begins
  always_comb begin
    drop_d = drop_count;
    pkt_d  = pkt_count;
    if (xfer && clip && drop_count != 16'hFFFF) drop_d = drop_count + 16'd1;
    if (xfer && gl) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (PW'(s) == grant && pkt_count[s*16 +: 16] != 16'hFFFF)
          pkt_d[s*16 +: 16] = pkt_count[s*16 +: 16] + 16'd1;
      end
    end
    if (state_d == CLEAR && state != CLEAR) begin
      drop_d = '0;
      pkt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      drop_count <= drop_d;
      pkt_count  <= pkt_d;
    end
  end
`endif

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter on an 8x4 screen with two sources.
module tb_draw_arbiter;

  localparam int unsigned NS = 2;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned CW = 1;
  localparam int unsigned HR = 8;
  localparam int unsigned VR = 4;

  logic               clk;
  logic               reset;
  logic               clear_req;
  logic [CW-1:0]      clear_color;
  logic [NS-1:0]      src_valid;
  logic [NS-1:0]      src_last;
  logic [NS*XW-1:0]   src_x;
  logic [NS*YW-1:0]   src_y;
  logic [NS*CW-1:0]   src_color;
  logic [NS-1:0]      src_ready;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [CW-1:0]      pixel_color;
  logic               pixel_we;
  logic               clearing;
  logic               cleared;
`ifdef DRAW_ARB_STATS_EN
  logic [15:0]        drop_count;
  logic [NS*16-1:0]   pkt_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  draw_arbiter #(
    .NUM_SRC(NS), .XW(XW), .YW(YW), .CW(CW), .H_RES(HR), .V_RES(VR)
  ) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_color(clear_color),
    .src_valid(src_valid), .src_last(src_last), .src_x(src_x), .src_y(src_y),
    .src_color(src_color), .src_ready(src_ready), .x(x), .y(y),
    .pixel_color(pixel_color), .pixel_we(pixel_we), .clearing(clearing),
    .cleared(cleared)
`ifdef DRAW_ARB_STATS_EN
    , .drop_count(drop_count), .pkt_count(pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic l, input int px,
                         input int py, input logic c);
    src_valid[s] = v;
    src_last[s]  = l;
    src_x[s*XW +: XW] = XW'(px);
    src_y[s*YW +: YW] = YW'(py);
    src_color[s*CW +: CW] = CW'(c);
  endtask

  task automatic check_reset_vals();
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_col", 32'(pixel_color), 0);
    check("rst_we", 32'(pixel_we), 0);
    check("rst_ready", 32'(src_ready), 0);
    check("rst_clearing", 32'(clearing), 0);
    check("rst_cleared", 32'(cleared), 0);
  endtask

  // Expect n raster pixels in colour col; pulse clear_req after pixel pulse_at
  task automatic scan(input logic [CW-1:0] col, input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      tick();
      check("clr_x", 32'(x), 32'(i % HR));
      check("clr_y", 32'(y), 32'(i / HR));
      check("clr_we", 32'(pixel_we), 1);
      check("clr_col", 32'(pixel_color), 32'(col));
      check("clr_clearing", 32'(clearing), 1);
      check("clr_cleared", 32'(cleared), (i == int'(HR*VR) - 1) ? 1 : 0);
      check("clr_ready", 32'(src_ready), 0);
      clear_req = (i == pulse_at);
    end
    clear_req = 1'b0;
  endtask

  task automatic check_idle();
    check("idle_we", 32'(pixel_we), 0);
    check("idle_cleared", 32'(cleared), 0);
    check("idle_clearing", 32'(clearing), 0);
    check("idle_ready", 32'(src_ready), 0);
  endtask

  task automatic check_write(input string tag, input int ex, input int ey, input int ec,
                             input int eready);
    check({tag, "_we"}, 32'(pixel_we), 1);
    check({tag, "_x"}, 32'(x), 32'(ex));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_col"}, 32'(pixel_color), 32'(ec));
    check({tag, "_ready"}, 32'(src_ready), 32'(eready));
  endtask

  int beat [NS];
  int pk [NS];
  logic [NS-1:0] hs;

  task automatic drive_rr();
    for (int s = 0; s < int'(NS); s++) begin
      if (pk[s] < 2) set_src(s, 1'b1, beat[s] == 1, s*4 + beat[s], 2*pk[s] + s, 1'(s));
      else           set_src(s, 1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_req = 1'b0;
    clear_color = '0;
    src_valid = '0;
    src_last = '0;
    src_x = '0;
    src_y = '0;
    src_color = '0;
    repeat (3) tick();
    check_reset_vals();
    reset = 1'b0;

    // Power-up clear in colour 0
    scan(1'b0, 32, -1);
    tick();
    check_idle();

    // Requested clear in colour 1, with an ignored mid-scan request
    clear_req = 1'b1;
    clear_color = 1'b1;
    tick();
    check("req_we", 32'(pixel_we), 0);
    clear_req = 1'b0;
    clear_color = 1'b0;
    scan(1'b1, 32, 10);
    tick();
    check_idle();

    // Round robin, two 2-pixel packets per source
    beat = '{0, 0};
    pk = '{0, 0};
    drive_rr();
    for (int c = 0; c < 12; c++) begin
      int r, p, g;
      hs = src_ready & src_valid;
      tick();
      for (int s = 0; s < int'(NS); s++) begin
        if (hs[s]) begin
          if (beat[s] == 1) begin
            beat[s] = 0;
            pk[s]++;
          end else begin
            beat[s]++;
          end
        end
      end
      r = c / 3;
      p = c % 3;
      g = r % 2;
      check("rr_ready", 32'(src_ready), (p < 2) ? (32'd1 << g) : 32'd0);
      check("rr_we", 32'(pixel_we), (p > 0) ? 1 : 0);
      if (p > 0) begin
        check("rr_x", 32'(x), 32'(g*4 + p - 1));
        check("rr_y", 32'(y), 32'(r));
        check("rr_col", 32'(pixel_color), 32'(g));
      end
      drive_rr();
    end
    tick();
    check_idle();

    // Packet lock: source 1 three beats, source 0 waiting
    set_src(1, 1'b1, 1'b0, 1, 0, 1'b1);
    tick();
    check("lock_grant", 32'(src_ready), 2);
    check("lock_we0", 32'(pixel_we), 0);
    tick();
    check_write("lock_b0", 1, 0, 1, 2);
    set_src(1, 1'b1, 1'b0, 2, 0, 1'b1);
    set_src(0, 1'b1, 1'b1, 5, 1, 1'b0);
    tick();
    check_write("lock_b1", 2, 0, 1, 2);
    set_src(1, 1'b1, 1'b1, 3, 0, 1'b1);
    tick();
    check_write("lock_b2", 3, 0, 1, 0);
    set_src(1, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    check("lock_idle_ready", 32'(src_ready), 1);
    check("lock_idle_we", 32'(pixel_we), 0);
    tick();
    check_write("lock_s0", 5, 1, 0, 0);
    set_src(0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    check_idle();

    // Clipping: (8,0) and (0,4) consumed silently, (3,2) written
    set_src(0, 1'b1, 1'b0, 8, 0, 1'b1);
    tick();
    check("clip_grant", 32'(src_ready), 1);
    tick();
    check("clip_we0", 32'(pixel_we), 0);
    check("clip_ready0", 32'(src_ready), 1);
    set_src(0, 1'b1, 1'b0, 0, 4, 1'b1);
    tick();
    check("clip_we1", 32'(pixel_we), 0);
    check("clip_ready1", 32'(src_ready), 1);
    set_src(0, 1'b1, 1'b1, 3, 2, 1'b1);
    tick();
    check_write("clip_ok", 3, 2, 1, 0);
`ifdef DRAW_ARB_STATS_EN
    check("stat_drop", 32'(drop_count), 2);
    check("stat_pkt0", 32'(pkt_count[15:0]), 4);
    check("stat_pkt1", 32'(pkt_count[31:16]), 3);
`endif
    set_src(0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    check_idle();

    // Clear requested mid-packet: remaining beat lands, then clear
    set_src(1, 1'b1, 1'b0, 1, 1, 1'b1);
    tick();
    check("pend_grant", 32'(src_ready), 2);
    tick();
    check_write("pend_b0", 1, 1, 1, 2);
    set_src(1, 1'b1, 1'b0, 2, 1, 1'b1);
    clear_req = 1'b1;
    tick();
    check_write("pend_b1", 2, 1, 1, 2);
    clear_req = 1'b0;
    set_src(1, 1'b1, 1'b1, 3, 1, 1'b1);
    tick();
    check_write("pend_b2", 3, 1, 1, 0);
    set_src(1, 1'b0, 1'b0, 0, 0, 1'b0);
    scan(1'b0, 11, -1);
`ifdef DRAW_ARB_STATS_EN
    check("stat_drop_clr", 32'(drop_count), 0);
    check("stat_pkt_clr", 32'(pkt_count), 0);
`endif

    // Reset in the middle of the clear restarts it from the origin
    reset = 1'b1;
    tick();
    check_reset_vals();
    reset = 1'b0;
    scan(1'b0, 32, -1);
    tick();
    check_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
